ccd_line2axis: RTL and testbench

Parametrised linear-CCD pixel-stream to AXI4-Stream packer. It is the successor to the fixed 12-bit/2048-column ccd2axis, sitting between the AFE driver (AD9945-class `tvalid`/`tdata` pixel stream) and the downstream video DMA. Relative to ccd2axis it adds:

- a generic column layout and generic output width with a runtime bit-window select;
- an internal FIFO that absorbs `m_axis_tready` backpressure;
- guaranteed `tlast`/`tuser` framing under overflow and short lines;
- optional dark-level subtraction from pre-dummy pixels.

---
 rtl/ccd_pkg.sv | 20 ++
 rtl/ccd_sync_fifo.sv | 56 +++++
 rtl/ccd_line2axis.sv | 229 ++++++++++++++++++++++
 tb/tb_ccd_line2axis.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and width helpers for the CCD line-capture blocks.
package ccd_pkg;

    // Per-beat AXIS sideband that travels with every pixel through the FIFO.
    typedef struct packed {
        logic last;
        logic user;
    } ccd_side_t;

    // Bits needed to hold the values 0..n.
    function automatic int ccd_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of the bit-window select; never narrower than one bit.
    function automatic int ccd_sel_w(input int dw, input int ow);
        return (dw - ow < 1) ? 1 : $clog2(dw - ow + 1);
    endfunction

endpackage

// File: rtl/ccd_sync_fifo.sv
// Synchronous show-ahead FIFO with a free-entry count. A write is accepted
// while full only when a read happens in the same cycle.
module ccd_sync_fifo
    import ccd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        empty,
    output logic [ccd_cnt_w(DEPTH)-1:0] free
);

    localparam int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = ccd_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full, do_wr, do_rd;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign free    = CNT_W'(DEPTH) - cnt;
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ccd_line2axis.sv
// Linear-CCD pixel stream to AXI4-Stream packer with tlast/tuser framing,
// bit-window select and a backpressure FIFO with a one-slot tlast reserve.
// Optional dark-level subtraction: define CCD_LINE2AXIS_DARK_SUB_EN.
module ccd_line2axis
    import ccd_pkg::*;
#(
    parameter int DATA_WIDTH      = 12,
    parameter int OUT_WIDTH       = 8,
    parameter int EFFECT_COLS     = 2048,
    parameter int PRE_DUMMY_COLS  = 32,
    parameter int POST_DUMMY_COLS = 8,
    parameter int ROW_W           = 11,
    parameter int FIFO_DEPTH      = 64,
    parameter int DARK_LOG2       = 4
) (
    input  logic                                         pixel_clk,
    input  logic                                         rst,
    input  logic                                         tvalid,
    input  logic [DATA_WIDTH-1:0]                        tdata,
    input  logic [ROW_W-1:0]                             rows,
    input  logic [ccd_sel_w(DATA_WIDTH, OUT_WIDTH)-1:0]  bit_sel,
    output logic [OUT_WIDTH-1:0]                         m_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic                                         m_axis_tuser,
    output logic [15:0]                                  drop_cnt,
    output logic                                         short_line
);

    localparam int SEL_W   = ccd_sel_w(DATA_WIDTH, OUT_WIDTH);
    localparam int MAX_SEL = DATA_WIDTH - OUT_WIDTH;
    localparam int COL_END = PRE_DUMMY_COLS + EFFECT_COLS;
    localparam int COL_W   = ccd_cnt_w(COL_END + POST_DUMMY_COLS);
    localparam int FREE_W  = ccd_cnt_w(FIFO_DEPTH);

    // Parameter sanity checks at elaboration.
    if (OUT_WIDTH > DATA_WIDTH) begin : g_bad_width
        $error("OUT_WIDTH must not exceed DATA_WIDTH");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end
    if ((1 << DARK_LOG2) > PRE_DUMMY_COLS) begin : g_bad_dark
        $error("dark window larger than the pre-dummy region");
    end

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        ccd_side_t            side;
    } beat_t;

    // ---------------- line / column tracking ----------------
    logic             wait_low, tv, tv_d, eff, final_col, line_end, line_start;
    logic [COL_W-1:0] col_q;
    logic [SEL_W-1:0] bs;
    logic             had_eff;
    logic [ROW_W-1:0] row_q, rows_lat;

    // After reset, a line already in flight is ignored until tvalid drops.
    assign tv         = tvalid & ~wait_low;
    assign eff        = tv && (col_q >= COL_W'(PRE_DUMMY_COLS)) && (col_q < COL_W'(COL_END));
    assign final_col  = (col_q == COL_W'(COL_END - 1));
    assign line_end   = tv_d & ~tv;
    assign line_start = tv & ~tv_d;
    assign bs         = (bit_sel > SEL_W'(MAX_SEL)) ? SEL_W'(MAX_SEL) : bit_sel;

    // Column counter, line-edge history and the post-reset resync flag.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            col_q    <= '0;
            tv_d     <= 1'b0;
            wait_low <= 1'b1;
        end else begin
            tv_d <= tv;
            if (!tvalid) wait_low <= 1'b0;
            if (!tv)                           col_q <= '0;
            else if (col_q != COL_W'(COL_END)) col_q <= col_q + COL_W'(1);
        end
    end

    // Row counter; the frame height is latched at the first effective pixel of row 0.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            row_q    <= '0;
            rows_lat <= ROW_W'(1);
            had_eff  <= 1'b0;
        end else begin
            if (eff) begin
                had_eff <= 1'b1;
                if (!had_eff && row_q == '0)
                    rows_lat <= (rows == '0) ? ROW_W'(1) : rows;
            end
            if (line_end) begin
                had_eff <= 1'b0;
                if (had_eff)
                    row_q <= (row_q >= rows_lat - ROW_W'(1)) ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // ---------------- pixel conditioning ----------------
    logic                  s_eff, s_final;
    logic [DATA_WIDTH-1:0] s_data;
    logic [SEL_W-1:0]      s_bs;

`ifdef CCD_LINE2AXIS_DARK_SUB_EN
    localparam int DARK_N = 1 << DARK_LOG2;
    localparam int ACC_W  = DATA_WIDTH + DARK_LOG2;

    logic [ACC_W-1:0]      acc;
    logic [DATA_WIDTH-1:0] dark_q, dark_now;
    logic                  in_win;

    assign in_win   = tv && (col_q < COL_W'(PRE_DUMMY_COLS)) &&
                      ({1'b0, col_q} + (COL_W+1)'(DARK_N) >= (COL_W+1)'(PRE_DUMMY_COLS));
    // The first effective pixel must see this line's average, not the latched one.
    assign dark_now = (col_q == COL_W'(PRE_DUMMY_COLS)) ? DATA_WIDTH'(acc >> DARK_LOG2) : dark_q;

    // Dark accumulator, cleared on the first sample of each line.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            acc    <= '0;
            dark_q <= '0;
        end else if (tv) begin
            acc <= ((col_q == '0) ? '0 : acc) + (in_win ? ACC_W'(tdata) : '0);
            if (col_q == COL_W'(PRE_DUMMY_COLS)) dark_q <= dark_now;
        end
    end

    // Registered clamp-at-zero subtraction stage.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s_eff   <= 1'b0;
            s_final <= 1'b0;
            s_data  <= '0;
            s_bs    <= '0;
        end else begin
            s_eff   <= eff;
            s_final <= final_col;
            s_data  <= (tdata > dark_now) ? tdata - dark_now : '0;
            s_bs    <= bs;
        end
    end
`else
    assign s_eff   = eff;
    assign s_final = final_col;
    assign s_data  = tdata;
    assign s_bs    = bs;
`endif

    // ---------------- staging and FIFO admission ----------------
    logic                 stg_vld, stg_last, frame_pend;
    logic [OUT_WIDTH-1:0] stg_data;
    beat_t                wr_beat, rd_beat;
    logic [FREE_W-1:0]    fifo_free;
    logic [FREE_W:0]      free_eff;
    logic                 fifo_empty, fifo_rd, fifo_wr, wr_ok;

    // A staged pixel always leaves the next cycle: either the next effective
    // pixel is behind it, or the line/effective region has ended and it is last.
    always_comb begin
        wr_beat           = '0;
        wr_beat.data      = stg_data;
        wr_beat.side.last = stg_last | ~s_eff;
        wr_beat.side.user = frame_pend;
    end

    assign fifo_rd  = m_axis_tvalid & m_axis_tready;
    assign free_eff = {1'b0, fifo_free} + (FREE_W+1)'(fifo_rd);
    // Keep one slot in reserve so a line's tlast beat can always get in.
    assign wr_ok    = wr_beat.side.last ? (free_eff >= (FREE_W+1)'(1))
                                        : (free_eff >= (FREE_W+1)'(2));
    assign fifo_wr  = stg_vld & wr_ok;

    // One-entry staging register holding the windowed pixel.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            stg_vld  <= 1'b0;
            stg_last <= 1'b0;
            stg_data <= '0;
        end else begin
            stg_vld <= s_eff;
            if (s_eff) begin
                stg_data <= OUT_WIDTH'(s_data >> s_bs);
                stg_last <= s_final;
            end
        end
    end

    // Frame-start flag: armed at each row-0 line start, consumed by the first written beat.
    always_ff @(posedge pixel_clk) begin
        if (rst)                            frame_pend <= 1'b1;
        else if (line_start && row_q == '0) frame_pend <= 1'b1;
        else if (fifo_wr)                   frame_pend <= 1'b0;
    end

    // Drop counter and sticky short-line flag.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            drop_cnt   <= '0;
            short_line <= 1'b0;
        end else begin
            if (stg_vld && !wr_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (line_end && col_q < COL_W'(COL_END))       short_line <= 1'b1;
        end
    end

    ccd_sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_beat),
        .rd_en   (fifo_rd),
        .rd_data (rd_beat),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    // Outputs read straight from the FIFO head, forced to zero while empty.
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : rd_beat.data;
    assign m_axis_tlast  = ~fifo_empty & rd_beat.side.last;
    assign m_axis_tuser  = ~fifo_empty & rd_beat.side.user;

endmodule

// File: tb/tb_ccd_line2axis.sv
// Directed bench for ccd_line2axis: framing, bit window, backpressure drops,
// short lines, mid-line reset and (when enabled) dark subtraction.
module tb_ccd_line2axis;

    localparam int PRE = 4;
    localparam int EFF = 8;
    localparam int POST = 2;

    logic        clk = 1'b0;
    logic        rst, tvalid, m_axis_tready;
    logic [11:0] tdata;
    logic [10:0] rows;
    logic [2:0]  bit_sel;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, short_line;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] q[$];

    ccd_line2axis #(
        .DATA_WIDTH(12), .OUT_WIDTH(8), .EFFECT_COLS(EFF), .PRE_DUMMY_COLS(PRE),
        .POST_DUMMY_COLS(POST), .ROW_W(11), .FIFO_DEPTH(16), .DARK_LOG2(2)
    ) dut (
        .pixel_clk(clk), .rst(rst), .tvalid(tvalid), .tdata(tdata), .rows(rows),
        .bit_sel(bit_sel), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .drop_cnt(drop_cnt), .short_line(short_line)
    );

    always #5 clk = ~clk;

    // Beat collector: {user, last, data} of every completed transfer.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready)
            q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] beat(input int i);
        return (i < q.size()) ? q[i] : 10'h3FF;
    endfunction

    task automatic px(input logic v, input logic [11:0] d);
        @(posedge clk);
        #1;
        tvalid = v;
        tdata  = d;
    endtask

    // Full or truncated line: zero pre-dummies, n effective pixels, post-dummies if full.
    task automatic send_line(input int n, input logic [11:0] fixed, input bit use_fixed);
        for (int i = 0; i < PRE; i++) px(1'b1, 12'h000);
        for (int k = 1; k <= n; k++) px(1'b1, use_fixed ? fixed : 12'(16 * k));
        if (n == EFF) for (int i = 0; i < POST; i++) px(1'b1, 12'h000);
        for (int i = 0; i < 3; i++) px(1'b0, 12'h000);
    endtask

    task automatic drain();
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] sels[3];
        logic [7:0] exps[3];
        logic [8:0] t3exp[16];
        int idx;

        rst = 1'b1; tvalid = 1'b0; tdata = '0; rows = 11'd2; bit_sel = 3'd4; m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_short", short_line, 0);
        rst = 1'b0;

        // 1: three ramp lines, frame of two rows
        q.delete();
        for (int l = 0; l < 3; l++) send_line(EFF, 12'h0, 1'b0);
        drain();
        chk("t1_count", q.size(), 24);
        for (int l = 0; l < 3; l++)
            for (int j = 0; j < EFF; j++)
                chk($sformatf("t1_l%0d_b%0d", l, j), beat(l * EFF + j),
                    {(j == 0 && l != 1), (j == EFF - 1), 8'(j + 1)});

        // 2: bit window select with clamp
        q.delete();
        sels[0] = 3'd0; sels[1] = 3'd4; sels[2] = 3'd7;
        exps[0] = 8'hBC; exps[1] = 8'hAB; exps[2] = 8'hAB;
        for (int l = 0; l < 3; l++) begin
            bit_sel = sels[l];
            send_line(EFF, 12'hABC, 1'b1);
        end
        drain();
        bit_sel = 3'd4;
        chk("t2_count", q.size(), 24);
        for (int l = 0; l < 3; l++)
            for (int j = 0; j < EFF; j++)
                chk($sformatf("t2_l%0d_b%0d", l, j), beat(l * EFF + j) & 10'h1FF,
                    {(j == EFF - 1), exps[l]});

        // 4: short line then a normal one
        q.delete();
        chk("t4_short_before", short_line, 0);
        send_line(5, 12'h0, 1'b0);
        chk("t4_short_set", short_line, 1);
        send_line(EFF, 12'h0, 1'b0);
        drain();
        chk("t4_count", q.size(), 13);
        for (int j = 0; j < 5; j++)
            chk($sformatf("t4_short_b%0d", j), beat(j) & 10'h1FF, {(j == 4), 8'(j + 1)});
        for (int j = 0; j < EFF; j++)
            chk($sformatf("t4_next_b%0d", j), beat(5 + j) & 10'h1FF, {(j == EFF - 1), 8'(j + 1)});
        chk("t4_short_sticky", short_line, 1);

        // 3: backpressure over full, short, full lines; 5 non-last pixels of the last line drop
        q.delete();
        m_axis_tready = 1'b0;
        send_line(EFF, 12'h0, 1'b0);
        send_line(5, 12'h0, 1'b0);
        send_line(EFF, 12'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_stall_valid", m_axis_tvalid, 1);
        chk("t3_stall_none", q.size(), 0);
        chk("t3_stall_data", m_axis_tdata, 8'd1);
        chk("t3_stall_last", m_axis_tlast, 0);
        chk("t3_drop", drop_cnt, 5);
        m_axis_tready = 1'b1;
        drain();
        idx = 0;
        for (int j = 0; j < EFF; j++) t3exp[idx++] = {(j == EFF - 1), 8'(j + 1)};
        for (int j = 0; j < 5; j++)   t3exp[idx++] = {(j == 4), 8'(j + 1)};
        t3exp[13] = {1'b0, 8'd1};
        t3exp[14] = {1'b0, 8'd2};
        t3exp[15] = {1'b1, 8'd8};
        chk("t3_count", q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t3_b%0d", i), beat(i) & 10'h1FF, t3exp[i]);
        chk("t3_drop_final", drop_cnt, 5);

        // 5: reset mid-line with three beats queued
        q.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < PRE; i++) px(1'b1, 12'h000);
        for (int k = 1; k <= 4; k++) px(1'b1, 12'(16 * k));
        @(posedge clk);
        #1;
        chk("t5_pre_valid", m_axis_tvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_tvalid", m_axis_tvalid, 0);
        chk("t5_tdata", m_axis_tdata, 0);
        chk("t5_tlast", m_axis_tlast, 0);
        chk("t5_tuser", m_axis_tuser, 0);
        chk("t5_drop", drop_cnt, 0);
        chk("t5_short", short_line, 0);
        for (int k = 5; k <= 7; k++) px(1'b1, 12'(16 * k));
        px(1'b0, 12'h000);
        px(1'b0, 12'h000);
        m_axis_tready = 1'b1;
        send_line(EFF, 12'h0, 1'b0);
        drain();
        chk("t5_count", q.size(), 8);
        for (int j = 0; j < EFF; j++)
            chk($sformatf("t5_b%0d", j), beat(j), {(j == 0), (j == EFF - 1), 8'(j + 1)});

`ifdef CCD_LINE2AXIS_DARK_SUB_EN
        // 6: dark average of 100 subtracted from 150 and 50
        q.delete();
        bit_sel = 3'd0;
        px(1'b1, 12'd100);
        px(1'b1, 12'd100);
        px(1'b1, 12'd104);
        px(1'b1, 12'd96);
        px(1'b1, 12'd150);
        px(1'b1, 12'd50);
        for (int i = 0; i < 3; i++) px(1'b0, 12'h000);
        drain();
        chk("t6_count", q.size(), 2);
        chk("t6_b0", beat(0) & 10'h1FF, {1'b0, 8'd50});
        chk("t6_b1", beat(1) & 10'h1FF, {1'b1, 8'd0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
